// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: FSM state encoding for the
// BCD-to-binary converter and the reverse double-dabble digit adjustment values.
package calc_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ_SUB    = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when any packed BCD nibble of the operand is outside 0..9.
    function automatic logic bcd_has_invalid(input logic [63:0] value, input int digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < digits; i++) begin
            if (value[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-digit correction for reverse double dabble: after the right shift a
// digit that came out >= 8 carried a "half ten" (8 instead of 5) and loses 3.
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(BCD_ADJ_THRESH);
    localparam logic [BCD_DIGIT_W-1:0] SUB    = BCD_DIGIT_W'(BCD_ADJ_SUB);

    assign digit_o = (digit_i >= THRESH) ? (digit_i - SUB) : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble), one shift and
// correct step per clock, start/busy/done handshake.
// Optional invalid-digit detection is compiled in with the BCD_CHECK_EN macro.
module bcd_to_bin
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd_in,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_W-1:0]              bin_out,
    output logic                          digit_err
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    logic [1:0]       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [SR_W-1:0]  sr_shift;
    logic [SR_W-1:0]  sr_adj;
    logic             err_q, err_d;
    logic             load_err;

    assign sr_shift = sr_q >> 1;
    assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    // Each BCD digit of the upper field is corrected independently after the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (sr_shift[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (sr_adj  [BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD_CHECK_EN
    assign load_err = bcd_has_invalid(64'(bcd_in), DIGITS);
`else
    assign load_err = 1'b0;
`endif

    // Next-state logic: load on accepted start, iterate in CONV, latch result on the last step.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            ST_CONV: begin
                sr_d  = sr_adj;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    bin_d   = err_q ? '0 : sr_adj[BIN_W-1:0];
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_CONV;
                    sr_d    = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    err_d   = load_err;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset that also aborts a conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q == ST_CONV);
    assign done    = (state_q == ST_DONE);
    assign bin_out = bin_q;

`ifdef BCD_CHECK_EN
    assign digit_err = done & err_q;
`else
    assign digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin with a scoreboard queue of expected results.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       bcd_in = 16'h0;
    logic              busy, done, digit_err;
    logic [BIN_W-1:0]  bin_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy_run = 0;

    typedef struct {
        logic [15:0]      bcd;
        logic [BIN_W-1:0] exp_bin;
        logic             exp_err;
        logic             chk_bin;
        int               exp_cyc;
    } exp_t;

    exp_t sb[$];

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected-value entry for an operand whose start is accepted at the next edge.
    task automatic push_exp(input logic [15:0] b);
        exp_t e;
        int   v;
        logic bad;
        v = 0;
        bad = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
            v = v * 10 + int'(b[i*4 +: 4]);
        end
        e.bcd = b;
`ifdef BCD_CHECK_EN
        e.exp_err = bad;
        e.exp_bin = bad ? '0 : BIN_W'(v);
        e.chk_bin = 1'b1;
`else
        e.exp_err = 1'b0;
        e.exp_bin = BIN_W'(v);
        e.chk_bin = !bad;
`endif
        e.exp_cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic convert(input logic [15:0] b);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        push_exp(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        tests++;
        assert (sb.size() === 0) else begin
            fails++;
            $error("FAIL drain_timeout: pending=%0d required=0", sb.size());
        end
    endtask

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            assert ((busy & done) === 1'b0) else begin
                fails++;
                $error("FAIL busy_done_overlap: busy=%b done=%b required not both", busy, done);
            end
            if (done === 1'b1) begin
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_done: bin_out=%0d required no done", bin_out);
                end
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("[TB] bcd=%h bin_out=%0d digit_err=%b cycle=%0d", e.bcd, bin_out, digit_err, cyc);
                    if (e.chk_bin) begin
                        tests++;
                        assert (bin_out === e.exp_bin) else begin
                            fails++;
                            $error("FAIL bin_out bcd=%h: got %0d required %0d", e.bcd, bin_out, e.exp_bin);
                        end
                    end
                    tests++;
                    assert (digit_err === e.exp_err) else begin
                        fails++;
                        $error("FAIL digit_err bcd=%h: got %b required %b", e.bcd, digit_err, e.exp_err);
                    end
                    tests++;
                    assert (cyc === e.exp_cyc) else begin
                        fails++;
                        $error("FAIL latency bcd=%h: done at cycle %0d required %0d", e.bcd, cyc, e.exp_cyc);
                    end
                    tests++;
                    assert (busy_run === BIN_W) else begin
                        fails++;
                        $error("FAIL busy_len bcd=%h: got %0d required %0d", e.bcd, busy_run, BIN_W);
                    end
                end
            end
        end
        busy_run = (busy === 1'b1) ? busy_run + 1 : 0;
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        tests++;
        assert ({busy, done, digit_err, bin_out} === {3'b000, {BIN_W{1'b0}}}) else begin
            fails++;
            $error("FAIL reset_state: busy=%b done=%b err=%b bin=%0d required all 0", busy, done, digit_err, bin_out);
        end
        rst = 1'b0;

        // Basic operands and boundaries
        convert(16'h0001); wait_drain();
        convert(16'h0010); wait_drain();
        convert(16'h0265); wait_drain();
        convert(16'h4095); wait_drain();
        convert(16'h9999); wait_drain();
        convert(16'h0000); wait_drain();

        // Start held high from DONE: back-to-back conversions every 15 cycles
        @(negedge clk);
        start = 1'b1; bcd_in = 16'h0123; push_exp(16'h0123);
        repeat (LAT) @(negedge clk);
        bcd_in = 16'h8765; push_exp(16'h8765);
        repeat (LAT) @(negedge clk);
        bcd_in = 16'h0999; push_exp(16'h0999);
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start during CONV with a different operand is ignored
        convert(16'h1234);
        repeat (4) @(negedge clk);
        start = 1'b1; bcd_in = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);

        // Reset mid-conversion
        convert(16'h0777);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        tests++;
        assert ({busy, done, digit_err, bin_out} === {3'b000, {BIN_W{1'b0}}}) else begin
            fails++;
            $error("FAIL mid_reset: busy=%b done=%b err=%b bin=%0d required all 0", busy, done, digit_err, bin_out);
        end
        rst = 1'b0;
        convert(16'h0265); wait_drain();

        // Invalid digit followed by a valid operand
        convert(16'h12A4); wait_drain();
        convert(16'h0042); wait_drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
